axis_fifo: RTL and testbench

Parametrised AXI4-Stream FIFO that buffers full beats (tdata, tkeep, tstrb, tlast, tuser) between an upstream master and a downstream slave in the accelerator datapath. It is the buffering successor to the plain AXI-Stream bundle: configurable data, user width and depth, a fill-level output, and an optional store-and-forward packet mode. It sits on DMA-to-compute and compute-to-DMA stream paths.

---
 rtl/axis_pkg.sv | 35 +++
 rtl/axis_fifo_ram.sv | 38 +++
 rtl/axis_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_axis_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI4-Stream FIFO: beat layout, level-width
// helper and the packet-mode bypass state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package axis_pkg;

    // Default stream widths; modules override them through their parameters.
    localparam int unsigned AXIS_DATA_WIDTH_DFLT = 64;
    localparam int unsigned AXIS_USER_WIDTH_DFLT = 1;
    localparam int unsigned AXIS_KEEP_WIDTH_DFLT = AXIS_DATA_WIDTH_DFLT / 8;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Reference beat layout at default widths. Modules declare the same
    // field order locally with their own parameter widths.
    typedef struct packed {
        logic [AXIS_DATA_WIDTH_DFLT-1:0] data;
        logic [AXIS_KEEP_WIDTH_DFLT-1:0] keep;
        logic [AXIS_KEEP_WIDTH_DFLT-1:0] strb;
        logic                            last;
        logic [AXIS_USER_WIDTH_DFLT-1:0] user;
    } axis_beat_t;

    // Packet-mode output gating: hold for full packets or cut through.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_BYPASS = 1'b1
    } bypass_state_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// ---------------------------------------------------------------------------
// axis_fifo_ram
// Simple dual-port storage: one synchronous write port, one asynchronous
// read port, no reset on the array (maps to distributed RAM).
// Ports:
//   i_clk      write clock
//   i_wr_en    write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  read data (combinational from i_rd_addr)
// ---------------------------------------------------------------------------
module axis_fifo_ram #(
    parameter  int unsigned DEPTH      = 16,
    parameter  int unsigned WIDTH      = 82,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Asynchronous read gives first-word-fall-through at the FIFO head.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_fifo.sv
// ---------------------------------------------------------------------------
// axis_fifo
// AXI4-Stream FIFO buffering full beats (tdata/tkeep/tstrb/tlast/tuser)
// with first-word-fall-through output and a fill-level output.
// Optional store-and-forward packet mode when AXIS_FIFO_PKT_MODE_EN is
// defined: output is held until a complete packet is stored, with a
// bypass (cut-through) escape for packets longer than DEPTH.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   s_axis_tvalid/tready             upstream handshake (tready registered)
//   s_axis_tdata/tkeep/tstrb/tlast/tuser  upstream beat
//   m_axis_tvalid/tready             downstream handshake
//   m_axis_tdata/tkeep/tstrb/tlast/tuser  head beat
//   level                            beats stored, 0..DEPTH
//   pkt_count                        complete packets stored (0 without
//                                    packet mode)
// ---------------------------------------------------------------------------
module axis_fifo
    import axis_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned USER_WIDTH = 1,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned LVL_WIDTH  = lvl_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [STRB_WIDTH-1:0] s_axis_tstrb,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [STRB_WIDTH-1:0] m_axis_tstrb,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    output logic [LVL_WIDTH-1:0]  level,
    output logic [LVL_WIDTH-1:0]  pkt_count
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    localparam int unsigned BEAT_WIDTH = $bits(beat_t);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LVL_WIDTH-1:0]  r_level;
    logic [LVL_WIDTH-1:0]  w_level_next;
    logic                  r_s_tready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_m_tvalid;
    beat_t                 w_wr_beat;
    beat_t                 w_rd_beat;
    logic [BEAT_WIDTH-1:0] w_rd_data;

    // Handshakes. tready is low when full, so a pop cannot free a slot for
    // a push in the same cycle.
    assign w_push = s_axis_tvalid && r_s_tready;
    assign w_pop  = w_m_tvalid && m_axis_tready;

    assign w_wr_beat = '{
        data: s_axis_tdata,
        keep: s_axis_tkeep,
        strb: s_axis_tstrb,
        last: s_axis_tlast,
        user: s_axis_tuser
    };

    axis_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_WIDTH)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_beat),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign w_rd_beat = beat_t'(w_rd_data);

    // Fill level after this edge.
    always_comb begin
        w_level_next = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_WIDTH'(1);
            2'b01:   w_level_next = r_level - LVL_WIDTH'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Pointers, level and registered upstream tready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_s_tready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_level    <= w_level_next;
            r_s_tready <= (w_level_next < LVL_WIDTH'(DEPTH));
        end
    end

`ifdef AXIS_FIFO_PKT_MODE_EN
    logic [LVL_WIDTH-1:0] r_pkt_count;
    logic [LVL_WIDTH-1:0] w_pkt_count_next;
    bypass_state_t        r_state;
    bypass_state_t        w_state_next;
    logic                 w_push_last;
    logic                 w_pop_last;

    assign w_push_last = w_push && s_axis_tlast;
    assign w_pop_last  = w_pop && w_rd_beat.last;

    // Complete-packet count.
    always_comb begin
        w_pkt_count_next = r_pkt_count;
        unique case ({w_push_last, w_pop_last})
            2'b10:   w_pkt_count_next = r_pkt_count + LVL_WIDTH'(1);
            2'b01:   w_pkt_count_next = r_pkt_count - LVL_WIDTH'(1);
            default: w_pkt_count_next = r_pkt_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count <= '0;
        end else begin
            r_pkt_count <= w_pkt_count_next;
        end
    end

    // Bypass state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Full with no complete packet would deadlock: cut through until the
    // oversized packet's tlast leaves.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if ((r_level == LVL_WIDTH'(DEPTH)) && (r_pkt_count == '0)) begin
                    w_state_next = ST_BYPASS;
                end
            end
            ST_BYPASS: begin
                if (w_pop_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_m_tvalid = (r_level != '0) &&
                        ((r_pkt_count != '0) || (r_state == ST_BYPASS));
    assign pkt_count  = r_pkt_count;
`else
    assign w_m_tvalid = (r_level != '0);
    assign pkt_count  = '0;
`endif

    assign s_axis_tready = r_s_tready;
    assign level         = r_level;

    assign m_axis_tvalid = w_m_tvalid;
    assign m_axis_tdata  = w_rd_beat.data;
    assign m_axis_tkeep  = w_rd_beat.keep;
    assign m_axis_tstrb  = w_rd_beat.strb;
    assign m_axis_tlast  = w_rd_beat.last;
    assign m_axis_tuser  = w_rd_beat.user;

endmodule

// File: tb/tb_axis_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo
// Self-checking bench for axis_fifo. A negedge monitor keeps a behavioural
// model (level, tready, tvalid, packet count, bypass) and a scoreboard queue
// of accepted beats; directed and random stimulus run against it.
// Packet-mode scenarios are compiled in with AXIS_FIFO_PKT_MODE_EN.
// ---------------------------------------------------------------------------
module tb_axis_fifo;

    localparam int unsigned DW    = 64;
    localparam int unsigned UW    = 1;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int unsigned BW    = DW + 2 * KW + 1 + UW;
`ifdef AXIS_FIFO_PKT_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [KW-1:0] s_tstrb;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [KW-1:0] m_tstrb;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic [LW-1:0] level;
    logic [LW-1:0] pkt_count;

    axis_fifo #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .level         (level),
        .pkt_count     (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- model + scoreboard ----------------
    logic [BW-1:0] sb_q [$];
    int unsigned   mdl_level;
    int unsigned   mdl_pkt;
    bit            mdl_rdy;
    bit            mdl_byp;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            mdl_level = 0;
            mdl_pkt   = 0;
            mdl_rdy   = 1'b0;
            mdl_byp   = 1'b0;
        end else begin : mon
            bit            exp_v;
            bit            push;
            bit            pop;
            bit            pop_last;
            logic [BW-1:0] exp_beat;
            exp_v = (mdl_level != 0) && (!PKT || (mdl_pkt != 0) || mdl_byp);
            check("level",     128'(level),     128'(mdl_level));
            check("s_tready",  128'(s_tready),  128'(mdl_rdy));
            check("m_tvalid",  128'(m_tvalid),  128'(exp_v));
            check("pkt_count", 128'(pkt_count), PKT ? 128'(mdl_pkt) : 128'(0));
            push     = s_tvalid && mdl_rdy;
            pop      = exp_v && m_tready;
            pop_last = 1'b0;
            if (pop) begin
                if (sb_q.size() == 0) begin
                    check("sb_pop_when_empty", 128'(sb_q.size()), 128'(1));
                end else begin
                    exp_beat = sb_q.pop_front();
                    pop_last = exp_beat[UW];
                    check("beat", 128'({m_tdata, m_tkeep, m_tstrb, m_tlast, m_tuser}), 128'(exp_beat));
                end
            end
            if (push) begin
                sb_q.push_back({s_tdata, s_tkeep, s_tstrb, s_tlast, s_tuser});
            end
            if (PKT) begin
                if (!mdl_byp && (mdl_level == DEPTH) && (mdl_pkt == 0)) begin
                    mdl_byp = 1'b1;
                end else if (mdl_byp && pop_last) begin
                    mdl_byp = 1'b0;
                end
                if (push && s_tlast && !pop_last) begin
                    mdl_pkt++;
                end else if (pop_last && !(push && s_tlast)) begin
                    mdl_pkt--;
                end
            end
            if (push && !pop) begin
                mdl_level++;
            end else if (pop && !push) begin
                mdl_level--;
            end
            mdl_rdy = (mdl_level < DEPTH);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] d, input logic l);
        s_tdata = d;
        s_tkeep = KW'($urandom);
        s_tstrb = KW'($urandom);
        s_tlast = l;
        s_tuser = UW'($urandom);
    endtask

    // Drive one beat and hold it until accepted; returns #1 after the edge.
    task automatic push_beat(input logic [DW-1:0] d, input logic l);
        bit acc;
        int n;
        n = 0;
        set_beat(d, l);
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("push_timeout", 128'(acc), 128'(1));
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_tready = 1'b1;
        while (level != 0 && n < 500) begin
            tick(1);
            n++;
        end
        check("drain_empty", 128'(level), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    initial begin
        logic [DW-1:0] d;
        int            sent;
        int            guard;
        bit            acc;
        bit            prod_done;

        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
        set_beat('0, 1'b0);
        tick(3);
        check("rst_level",    128'(level),     128'(0));
        check("rst_m_tvalid", 128'(m_tvalid),  128'(0));
        check("rst_s_tready", 128'(s_tready),  128'(0));
        check("rst_pkt",      128'(pkt_count), 128'(0));
        rst = 1'b0;
        tick(1);
        check("tready_first_edge", 128'(s_tready), 128'(1));
        tick(1);

        // Latency: each beat at the head one cycle after its push.
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 64'h11 + 64'(i);
            push_beat(d, 1'b1);
            check("t1_valid", 128'(m_tvalid), 128'(1));
            check("t1_data",  128'(m_tdata),  128'(d));
            check("t1_level", 128'(level),    128'(1));
        end
        drain();

        // Fill to DEPTH, 17th beat held, one pop releases it.
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_beat(64'h100 + 64'(i), 1'b1);
        end
        check("t2_level_full", 128'(level),    128'(16));
        check("t2_tready_lo",  128'(s_tready), 128'(0));
        set_beat(64'h200, 1'b1);
        s_tvalid = 1'b1;
        tick(3);
        check("t2_level_held", 128'(level),    128'(16));
        check("t2_head",       128'(m_tdata),  128'(64'h100));
        m_tready = 1'b1;
        tick(1);
        m_tready = 1'b0;
        check("t2_level_pop",  128'(level),    128'(15));
        check("t2_tready_hi",  128'(s_tready), 128'(1));
        tick(1);
        s_tvalid = 1'b0;
        check("t2_level_refill", 128'(level),    128'(16));
        check("t2_tready_relo",  128'(s_tready), 128'(0));
        drain();

        // Random back-pressure on both sides.
        sent = 0; guard = 0; prod_done = 1'b0;
        fork
            begin
                while (sent < 1000 && guard < 20000) begin
                    if (!s_tvalid && ($urandom_range(1, 0) == 1)) begin
                        set_beat({$urandom, $urandom}, PKT ? 1'b1 : 1'($urandom_range(1, 0)));
                        s_tvalid = 1'b1;
                    end
                    @(negedge clk);
                    acc = s_tvalid && s_tready;
                    @(posedge clk);
                    #1;
                    guard++;
                    if (acc) begin
                        sent++;
                        s_tvalid = 1'b0;
                    end
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    m_tready = 1'($urandom_range(1, 0));
                    tick(1);
                end
            end
        join
        check("t3_sent", 128'(sent), 128'(1000));
        drain();
        check("t3_sb_empty", 128'(sb_q.size()), 128'(0));

        // Reset mid-stream with 5 beats stored.
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_beat(64'h300 + 64'(i), 1'b1);
        end
        check("t6_level5", 128'(level), 128'(5));
        rst = 1'b1;
        tick(1);
        check("t6_level",    128'(level),     128'(0));
        check("t6_m_tvalid", 128'(m_tvalid),  128'(0));
        check("t6_s_tready", 128'(s_tready),  128'(0));
        check("t6_pkt",      128'(pkt_count), 128'(0));
        rst = 1'b0;
        tick(2);
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_beat(64'h380 + 64'(i), 1'(i == 3));
        end
        drain();
        check("t6_sb_empty", 128'(sb_q.size()), 128'(0));

`ifdef AXIS_FIFO_PKT_MODE_EN
        // Store-and-forward: nothing out until tlast is stored.
        m_tready = 1'b1;
        push_beat(64'h400, 1'b0);
        check("p1_hold0", 128'(m_tvalid), 128'(0));
        push_beat(64'h401, 1'b0);
        check("p1_hold1", 128'(m_tvalid), 128'(0));
        push_beat(64'h402, 1'b1);
        check("p1_valid", 128'(m_tvalid),  128'(1));
        check("p1_pkt1",  128'(pkt_count), 128'(1));
        drain();
        check("p1_pkt0",  128'(pkt_count), 128'(0));

        // Oversized packet: bypass engages at full, no deadlock.
        m_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push_beat(64'h500 + 64'(i), 1'(i == 19));
                end
            end
            begin
                guard = 0;
                while (level != LW'(DEPTH) && guard < 500) begin
                    tick(1);
                    guard++;
                end
                check("p2_full",        128'(level),    128'(16));
                check("p2_not_yet_byp", 128'(m_tvalid), 128'(0));
                tick(1);
                check("p2_bypass",      128'(m_tvalid), 128'(1));
                m_tready = 1'b1;
            end
        join
        drain();
        check("p2_pkt0", 128'(pkt_count), 128'(0));
        push_beat(64'h600, 1'b0);
        check("p2_bypass_cleared", 128'(m_tvalid), 128'(0));
        push_beat(64'h601, 1'b1);
        drain();
        check("p2_sb_empty", 128'(sb_q.size()), 128'(0));
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
